// File: rtl/divider_sched_pkg.sv
// divider_sched_pkg: shared types for the divider scheduler slice.
// Holds the state encoding of the iterative divider core.
// No ports.
package divider_sched_pkg;

  typedef enum logic {
    DIV_IDLE = 1'b0,
    DIV_RUN  = 1'b1
  } div_state_t;

endpackage

// File: rtl/divider_sched_dividerFsm.sv
// dividerFsm: iterative unsigned restoring divider, one quotient bit per enabled cycle.
// Latency: o_busy high for WIDTH enabled cycles after i_begin; results valid once o_busy is low.
// Backpressure: none; i_begin is only honoured while idle, i_cg=0 freezes all state.
// Ports: i_clk/i_rst/i_cg clock, async reset, enable; i_begin/i_dividend/i_divisor start;
//        o_busy, o_quotient, o_remainder results.
module dividerFsm
  import divider_sched_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int ABSTRACT_MODEL = 0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_cg,
  input  logic             i_begin,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_busy,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder
);

  localparam int CW = $clog2(WIDTH + 1);

  div_state_t       st_q, st_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dsr_d   = dsr_q;
    // Quotient register doubles as the dividend shift register: its MSB
    // feeds the partial remainder each step, the new quotient bit enters at LSB.
    shifted = {rem_q, quo_q[WIDTH-1]};
    diff    = shifted - {1'b0, dsr_q};
    case (st_q)
      DIV_IDLE: begin
        if (i_begin) begin
          st_d  = DIV_RUN;
          cnt_d = CW'(WIDTH);
          dsr_d = i_divisor;
          if (ABSTRACT_MODEL != 0) begin
            quo_d = i_dividend / i_divisor;
            rem_d = i_dividend % i_divisor;
          end else begin
            quo_d = i_dividend;
            rem_d = '0;
          end
        end
      end
      default: begin
        if (ABSTRACT_MODEL == 0) begin
          if (shifted >= {1'b0, dsr_q}) begin
            rem_d = diff[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = shifted[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
          end
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) st_d = DIV_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      st_q  <= DIV_IDLE;
      cnt_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      dsr_q <= '0;
    end else if (i_cg) begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
      dsr_q <= dsr_d;
    end
  end

  assign o_busy      = (st_q == DIV_RUN);
  assign o_quotient  = quo_q;
  assign o_remainder = rem_q;

endmodule

// File: rtl/divider_sched.sv
// divider_sched: round-robin arbiter sharing one iterative divider among N_REQ requesters.
// Latency: grant to o_rsp_valid is WIDTH+2 enabled cycles, or 1 cycle for divide-by-zero.
// Backpressure: one operation at a time; results held until the owner asserts i_rsp_ready.
// Ports: i_clk/i_rst/i_cg clock, async reset, enable; i_req_* per-requester request bus
//        with o_req_ready grant; o_rsp_valid/i_rsp_ready response handshake; o_rsp_* results; o_busy.
module divider_sched #(
  parameter int WIDTH          = 8,
  parameter int N_REQ          = 4,
  parameter int ABSTRACT_MODEL = 0
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_cg,
  input  logic [N_REQ-1:0]       i_req_valid,
  output logic [N_REQ-1:0]       o_req_ready,
  input  logic [N_REQ*WIDTH-1:0] i_req_dividend,
  input  logic [N_REQ*WIDTH-1:0] i_req_divisor,
  output logic [N_REQ-1:0]       o_rsp_valid,
  input  logic [N_REQ-1:0]       i_rsp_ready,
  output logic [WIDTH-1:0]       o_rsp_quotient,
  output logic [WIDTH-1:0]       o_rsp_remainder,
  output logic                   o_rsp_dbz,
  output logic                   o_busy
);

  localparam int IDXW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Lowest offset from last+1 wins; scanning offsets high to low lets the
  // nearest valid requester overwrite any farther one.
  function automatic logic [IDXW-1:0] rr_pick(input logic [N_REQ-1:0] v,
                                              input logic [IDXW-1:0]  last);
    logic [IDXW-1:0] pick;
    logic [IDXW-1:0] idx;
    pick = last;
    for (int i = N_REQ; i >= 1; i--) begin
      idx = IDXW'((int'(last) + i) % N_REQ);
      if (v[idx]) pick = idx;
    end
    return pick;
  endfunction

  state_t           state_q, state_d;
  logic [IDXW-1:0]  last_q, last_d;
  logic [IDXW-1:0]  owner_q, owner_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [IDXW-1:0]  grant_idx;
  logic [WIDTH-1:0] sel_dvd, sel_dvs;
  logic [N_REQ-1:0] req_ready, rsp_vld;
  logic             div_begin, div_busy;
  logic [WIDTH-1:0] div_quo, div_rem;

  always_comb begin
    grant_idx = rr_pick(i_req_valid, last_q);
    sel_dvd   = '0;
    sel_dvs   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (grant_idx == IDXW'(k)) begin
        sel_dvd = i_req_dividend[k*WIDTH +: WIDTH];
        sel_dvs = i_req_divisor[k*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    owner_d   = owner_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dbz_d     = dbz_q;
    req_ready = '0;
    rsp_vld   = '0;
    div_begin = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Reset term keeps the combinational grant quiet while reset is held.
        if (i_cg && !i_rst && (|i_req_valid)) begin
          req_ready[grant_idx] = 1'b1;
          last_d  = grant_idx;
          owner_d = grant_idx;
          if (sel_dvs == '0) begin
            quo_d   = '1;
            rem_d   = sel_dvd;
            dbz_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            div_begin = 1'b1;
            state_d   = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        if (!div_busy) begin
          quo_d   = div_quo;
          rem_d   = div_rem;
          dbz_d   = 1'b0;
          state_d = ST_RESP;
        end
      end
      default: begin
        rsp_vld[owner_q] = 1'b1;
        if (i_rsp_ready[owner_q]) state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      last_q  <= IDXW'(N_REQ - 1);
      owner_q <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else if (i_cg) begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  dividerFsm #(
    .WIDTH          (WIDTH),
    .ABSTRACT_MODEL (ABSTRACT_MODEL)
  ) u_div (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_cg        (i_cg),
    .i_begin     (div_begin),
    .i_dividend  (sel_dvd),
    .i_divisor   (sel_dvs),
    .o_busy      (div_busy),
    .o_quotient  (div_quo),
    .o_remainder (div_rem)
  );

  assign o_req_ready     = req_ready;
  assign o_rsp_valid     = rsp_vld;
  assign o_rsp_quotient  = quo_q;
  assign o_rsp_remainder = rem_q;
  assign o_rsp_dbz       = dbz_q;
  assign o_busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_divider_sched.sv
module tb_divider_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        cg;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_dividend;
  logic [31:0] req_divisor;
  logic [3:0]  rsp_valid;
  logic [3:0]  rsp_ready;
  logic [7:0]  rsp_q;
  logic [7:0]  rsp_r;
  logic        rsp_dbz;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;
  int begin_cnt = 0;

  always #5 clk = ~clk;

  divider_sched #(.WIDTH(8), .N_REQ(4), .ABSTRACT_MODEL(0)) u_dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_cg            (cg),
    .i_req_valid     (req_valid),
    .o_req_ready     (req_ready),
    .i_req_dividend  (req_dividend),
    .i_req_divisor   (req_divisor),
    .o_rsp_valid     (rsp_valid),
    .i_rsp_ready     (rsp_ready),
    .o_rsp_quotient  (rsp_q),
    .o_rsp_remainder (rsp_r),
    .o_rsp_dbz       (rsp_dbz),
    .o_busy          (busy)
  );

  // Counts divider start pulses that actually take effect.
  always @(posedge clk) if (!rst && cg && u_dut.div_begin) begin_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int k, input logic [7:0] a, input logic [7:0] b);
    req_dividend[k*8 +: 8] = a;
    req_divisor[k*8 +: 8]  = b;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    rsp_ready = '0;
    cg = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Called at the grant-cycle negedge; returns cycles until first rsp_valid.
  // Drops and scrambles requests right after the grant; cg is low in
  // cycles [cg_s, cg_s+cg_n).
  task automatic wait_rsp(input int cg_s, input int cg_n, output int lat);
    lat = 0;
    while (lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) begin
        req_valid    = '0;
        req_dividend = {4{8'hAA}};
        req_divisor  = {4{8'h03}};
      end
      cg = !(lat >= cg_s && lat < cg_s + cg_n);
      @(negedge clk);
      if (|rsp_valid) break;
    end
    cg = 1'b1;
  endtask

  task automatic finish_rsp(input int k, input string tag);
    rsp_ready = 4'(1 << k);
    @(posedge clk); #1;
    rsp_ready = '0;
    @(negedge clk);
    check({tag, "_idle_valid"}, {28'd0, rsp_valid}, 32'd0);
    check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic do_op(input string tag, input int k, input logic [7:0] a, input logic [7:0] b,
                       input int cg_s, input int cg_n, input int exp_lat,
                       input logic [7:0] eq, input logic [7:0] er, input logic edbz);
    int lat;
    @(posedge clk); #1;
    req_valid[k] = 1'b1;
    set_op(k, a, b);
    @(negedge clk);
    check({tag, "_grant"}, {28'd0, req_ready}, 32'(1 << k));
    wait_rsp(cg_s, cg_n, lat);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_rsp_valid"}, {28'd0, rsp_valid}, 32'(1 << k));
    check({tag, "_q"}, {24'd0, rsp_q}, {24'd0, eq});
    check({tag, "_r"}, {24'd0, rsp_r}, {24'd0, er});
    check({tag, "_dbz"}, {31'd0, rsp_dbz}, {31'd0, edbz});
    finish_rsp(k, tag);
  endtask

  initial begin
    int lat;
    int b0;
    int ngr;
    int rsp_seen;
    int order[6];
    logic [3:0] onehot;
    rst = 1'b1;
    cg = 1'b1;
    req_valid = '0;
    rsp_ready = '0;
    req_dividend = '0;
    req_divisor = '0;
    order = '{default: 0};

    // Reset values while reset is held.
    @(posedge clk); #1;
    check("rst_ready", {28'd0, req_ready}, 32'd0);
    check("rst_rsp_valid", {28'd0, rsp_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_dbz", {31'd0, rsp_dbz}, 32'd0);
    check("rst_q", {24'd0, rsp_q}, 32'd0);
    check("rst_r", {24'd0, rsp_r}, 32'd0);
    do_reset();

    // 100/7 on requester 0, grant cycle 0, response at cycle 10.
    do_op("div100_7", 0, 8'd100, 8'd7, 0, 0, 10, 8'd14, 8'd2, 1'b0);

    // 55/0 on requester 2: immediate response, divider never started.
    b0 = begin_cnt;
    do_op("dbz55", 2, 8'd55, 8'd0, 0, 0, 1, 8'hFF, 8'd55, 1'b1);
    check("dbz_no_begin", begin_cnt, b0);

    // Round robin with all four requesting from reset.
    do_reset();
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) set_op(k, 8'(k * 10 + 1), 8'd0);
    req_valid = 4'hF;
    rsp_ready = 4'hF;
    ngr = 0;
    for (int c = 0; c < 20 && ngr < 6; c++) begin
      @(negedge clk);
      if (|req_ready) begin
        onehot = req_ready;
        check("rr_onehot", $countones(onehot), 1);
        for (int k = 0; k < 4; k++) if (onehot[k]) order[ngr] = k;
        ngr++;
      end
      @(posedge clk); #1;
    end
    check("rr_count", ngr, 6);
    for (int g = 0; g < 6; g++) check($sformatf("rr_order%0d", g), order[g], g % 4);
    req_valid = '0;
    rsp_ready = '0;
    repeat (3) @(posedge clk);

    // Response stall on requester 0 while requester 1 waits.
    do_reset();
    @(posedge clk); #1;
    set_op(0, 8'd100, 8'd0);
    set_op(1, 8'd200, 8'd9);
    req_valid = 4'b0011;
    rsp_ready = 4'b0010;
    @(negedge clk);
    check("stall_grant0", {28'd0, req_ready}, 32'h1);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("stall_rsp_valid", {28'd0, rsp_valid}, 32'h1);
      check("stall_ready", {28'd0, req_ready}, 32'h0);
      check("stall_q", {24'd0, rsp_q}, 32'hFF);
      check("stall_r", {24'd0, rsp_r}, 32'd100);
      check("stall_dbz", {31'd0, rsp_dbz}, 32'd1);
    end
    @(posedge clk); #1;
    rsp_ready = 4'b0001;
    @(negedge clk);
    check("stall_hs_valid", {28'd0, rsp_valid}, 32'h1);
    check("stall_hs_noready", {28'd0, req_ready}, 32'h0);
    @(posedge clk); #1;
    rsp_ready = '0;
    @(negedge clk);
    check("stall_grant1", {28'd0, req_ready}, 32'h2);
    wait_rsp(0, 0, lat);
    check("req1_latency", lat, 10);
    check("req1_rsp_valid", {28'd0, rsp_valid}, 32'h2);
    check("req1_q", {24'd0, rsp_q}, 32'd22);
    check("req1_r", {24'd0, rsp_r}, 32'd2);
    finish_rsp(1, "req1");

    // Reset in the fourth BUSY cycle discards the operation.
    @(posedge clk); #1;
    set_op(0, 8'd100, 8'd7);
    req_valid = 4'b0001;
    @(negedge clk);
    check("rstbusy_grant", {28'd0, req_ready}, 32'h1);
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      if (c == 1) req_valid = '0;
    end
    check("rstbusy_pre_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("rstbusy_busy", {31'd0, busy}, 32'd0);
    check("rstbusy_valid", {28'd0, rsp_valid}, 32'd0);
    check("rstbusy_ready", {28'd0, req_ready}, 32'd0);
    check("rstbusy_q", {24'd0, rsp_q}, 32'd0);
    check("rstbusy_r", {24'd0, rsp_r}, 32'd0);
    check("rstbusy_dbz", {31'd0, rsp_dbz}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    rsp_seen = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (|rsp_valid || busy) rsp_seen++;
    end
    check("rstbusy_discarded", rsp_seen, 0);
    do_op("div200_9", 0, 8'd200, 8'd9, 0, 0, 10, 8'd22, 8'd2, 1'b0);

    // Clock enable low for three BUSY cycles stretches latency by three.
    do_op("cg100_7", 1, 8'd100, 8'd7, 3, 3, 13, 8'd14, 8'd2, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/divider_sched.md
DIVIDER_SCHED -- requirements
Module: divider_sched

Interface
REQ-001 Parameter WIDTH, default 8: operand/result width in bits.
REQ-002 Parameter N_REQ, default 4: number of requesters, 2..16.
REQ-003 Parameter ABSTRACT_MODEL, default 0: passed unchanged to the divider sub-module.
REQ-004 i_clk  input  1  sole clock; all state on rising edge.
REQ-005 i_rst  input  1  reset, asynchronous, active-high.
REQ-006 i_cg  input  1  clock enable; when 0, all state including the divider holds.
REQ-007 i_req_valid  input  N_REQ  per-requester request valid.
REQ-008 o_req_ready  output  N_REQ  per-requester accept, one-hot or zero.
REQ-009 i_req_dividend  input  N_REQ*WIDTH  requester k at bits [k*WIDTH +: WIDTH].
REQ-010 i_req_divisor  input  N_REQ*WIDTH  same packing as dividend.
REQ-011 o_rsp_valid  output  N_REQ  per-requester response valid, one-hot or zero.
REQ-012 i_rsp_ready  input  N_REQ  per-requester response accept.
REQ-013 o_rsp_quotient / o_rsp_remainder  output  WIDTH each  registered results.
REQ-014 o_rsp_dbz  output  1  response was a divide-by-zero.
REQ-015 o_busy  output  1  high whenever the state is not IDLE.

Function
REQ-016 The FSM SHALL have states IDLE, BUSY and RESP.
REQ-017 In IDLE with i_cg=1 and any i_req_valid set, the block SHALL grant one requester, assert o_req_ready for it only, and capture its operands that cycle.
REQ-018 Arbitration SHALL be round-robin: search starts at last_grant+1 modulo N_REQ, and last_grant updates on every grant.
REQ-019 o_req_ready SHALL be 0 in BUSY and RESP, and 0 in IDLE when no request is valid.
REQ-020 A grant with divisor != 0 SHALL pulse divider i_begin in the grant cycle and move to BUSY.
REQ-021 In BUSY, the first cycle the divider o_busy is 0, the block SHALL register quotient, remainder and dbz=0, then move to RESP.
REQ-022 Latency from grant cycle t to first o_rsp_valid cycle SHALL be WIDTH+2 cycles of enabled clock.
REQ-023 A grant with divisor == 0 SHALL NOT start the divider. It SHALL register quotient = all-ones, remainder = dividend and dbz=1, and move to RESP; o_rsp_valid is high at t+1.
REQ-024 In RESP, o_rsp_valid SHALL be set only for the granted requester, and the result outputs SHALL stay stable until i_rsp_ready for that requester is high.
REQ-025 On that handshake the block SHALL return to IDLE; the next grant is no earlier than the following cycle.
REQ-026 i_rsp_ready bits of non-owning requesters SHALL be ignored.
REQ-027 Changes to i_req_valid or operands after the grant SHALL NOT affect an operation in flight.
REQ-028 Dropping i_req_valid before a grant SHALL be legal; the dropped request is not serviced.

Reset
REQ-029 Reset SHALL force state=IDLE and last_grant=N_REQ-1, so requester 0 wins first.
REQ-030 Reset SHALL force o_req_ready=0, o_rsp_valid=0, o_busy=0, o_rsp_dbz=0, quotient=0 and remainder=0.
REQ-031 Reset SHALL also reset the divider, and any in-flight operation SHALL be discarded with no response.

Structure
REQ-032 One sub-module SHALL be instantiated: dividerFsm (begin pulse, busy for WIDTH cycles, results valid when busy low), sharing i_clk, i_cg and i_rst.
REQ-033 State encodings and the round-robin function SHALL be local to the module; no shared package is required.
REQ-034 Total RTL SHALL be 120-400 lines, excluding the divider.

Verification (WIDTH=8, N_REQ=4)
REQ-035 Req0 100/7 at cycle 0 -> grant at 0; rsp_valid[0] at cycle 10; q=14, r=2, dbz=0.
REQ-036 Req2 55/0 -> rsp_valid[2] next cycle; q=0xFF, r=55, dbz=1; divider begin never pulses.
REQ-037 All four request continuously from reset with rsp_ready=1 -> grant order 0,1,2,3,0,1.
REQ-038 rsp_ready[0] held low 5 cycles while req1 is valid -> rsp outputs stable, ready[1] stays 0, req1 granted the cycle after the handshake.
REQ-039 Assert i_rst at cycle 4 of BUSY -> all outputs at reset values immediately; a later 200/9 returns q=22, r=2.
REQ-040 i_cg low for 3 cycles during BUSY on 100/7 -> response 3 cycles later, results unchanged.
